// File: rtl/jb_unit_btb_if.sv
// Bundle between the EX-stage jump/branch unit, its issuing pipeline and fetch's BTB lookup.
// master drives the EX inputs and if_pc; slave is the unit itself.
interface jb_unit_btb_if #(
  parameter int unsigned XLEN = 32
);
  logic            ex_valid;
  logic [4:0]      opcode;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] operand1;
  logic [XLEN-1:0] operand2;
  logic            br_cond;
  logic            ex_pred_taken;
  logic [XLEN-1:0] ex_pred_target;
  logic            stall;
  logic            flush;
  logic            jb_valid;
  logic [XLEN-1:0] jb_out;
  logic            jb_taken;
  logic            jb_mispredict;
  logic [XLEN-1:0] jb_redirect_pc;
  logic [XLEN-1:0] if_pc;
  logic            pred_hit;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;

  modport master (
    output ex_valid, opcode, pc, operand1, operand2, br_cond, ex_pred_taken, ex_pred_target,
    output stall, flush, if_pc,
    input  jb_valid, jb_out, jb_taken, jb_mispredict, jb_redirect_pc,
    input  pred_hit, pred_taken, pred_target
  );

  modport slave (
    input  ex_valid, opcode, pc, operand1, operand2, br_cond, ex_pred_taken, ex_pred_target,
    input  stall, flush, if_pc,
    output jb_valid, jb_out, jb_taken, jb_mispredict, jb_redirect_pc,
    output pred_hit, pred_taken, pred_target
  );
endinterface

// File: rtl/jb_unit_btb.sv
// EX-stage jump/branch resolver with registered results and mispredict detection, plus a
// direct-mapped BTB with 2-bit saturating counters that fetch reads combinationally.
module jb_unit_btb #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned BTB_DEPTH = 16
) (
  input logic           clk,
  input logic           rst,
  jb_unit_btb_if.slave  bus
);
  localparam int unsigned IDX_W = $clog2(BTB_DEPTH);
  localparam int unsigned TAG_W = XLEN - IDX_W - 2;

  localparam logic [4:0] OpBranch = 5'b11000;
  localparam logic [4:0] OpJal    = 5'b11011;
  localparam logic [4:0] OpJalr   = 5'b11001;

  logic             btb_valid_q  [BTB_DEPTH];
  logic [TAG_W-1:0] btb_tag_q    [BTB_DEPTH];
  logic [XLEN-1:0]  btb_target_q [BTB_DEPTH];
  logic [1:0]       btb_ctr_q    [BTB_DEPTH];

  logic            jb_valid_q;
  logic [XLEN-1:0] jb_out_q;
  logic            jb_taken_q;
  logic            jb_mispredict_q;
  logic [XLEN-1:0] jb_redirect_pc_q;

  // Lookup reads only stored state, so a same-cycle update is seen next cycle.
  logic [IDX_W-1:0] rd_idx;
  assign rd_idx           = bus.if_pc[IDX_W+1:2];
  assign bus.pred_hit     = btb_valid_q[rd_idx] &&
                            (btb_tag_q[rd_idx] == bus.if_pc[XLEN-1:IDX_W+2]);
  assign bus.pred_taken   = bus.pred_hit && btb_ctr_q[rd_idx][1];
  assign bus.pred_target  = btb_target_q[rd_idx];

  logic             is_br;
  logic             is_jb;
  logic [XLEN-1:0]  sum;
  logic [XLEN-1:0]  tgt;
  logic [XLEN-1:0]  fall;
  logic             taken;
  logic             mispredict;
  logic [IDX_W-1:0] wr_idx;
  logic [TAG_W-1:0] wr_tag;
  logic             upd_hit;
  logic [1:0]       ctr_upd;

  always_comb begin
    is_br      = (bus.opcode == OpBranch);
    is_jb      = is_br || (bus.opcode == OpJal) || (bus.opcode == OpJalr);
    sum        = bus.operand1 + bus.operand2;
    tgt        = (bus.opcode == OpJalr) ? {sum[XLEN-1:1], 1'b0} : sum;
    fall       = bus.pc + XLEN'(4);
    taken      = is_br ? bus.br_cond : 1'b1;
    mispredict = (taken != bus.ex_pred_taken) ||
                 (taken && bus.ex_pred_taken && (tgt != bus.ex_pred_target));
    wr_idx     = bus.pc[IDX_W+1:2];
    wr_tag     = bus.pc[XLEN-1:IDX_W+2];
    upd_hit    = btb_valid_q[wr_idx] && (btb_tag_q[wr_idx] == wr_tag);
    ctr_upd    = btb_ctr_q[wr_idx];
    if (taken) begin
      if (btb_ctr_q[wr_idx] != 2'b11) ctr_upd = btb_ctr_q[wr_idx] + 2'b01;
    end else begin
      if (btb_ctr_q[wr_idx] != 2'b00) ctr_upd = btb_ctr_q[wr_idx] - 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      jb_valid_q       <= 1'b0;
      jb_out_q         <= '0;
      jb_taken_q       <= 1'b0;
      jb_mispredict_q  <= 1'b0;
      jb_redirect_pc_q <= '0;
      for (int i = 0; i < BTB_DEPTH; i++) begin
        btb_valid_q[i]  <= 1'b0;
        btb_tag_q[i]    <= '0;
        btb_target_q[i] <= '0;
        btb_ctr_q[i]    <= 2'b01;
      end
    end else if (!bus.stall) begin
      if (bus.flush || !bus.ex_valid) begin
        jb_valid_q      <= 1'b0;
        jb_taken_q      <= 1'b0;
        jb_mispredict_q <= 1'b0;
      end else if (is_jb) begin
        jb_valid_q       <= 1'b1;
        jb_out_q         <= tgt;
        jb_taken_q       <= taken;
        jb_mispredict_q  <= mispredict;
        jb_redirect_pc_q <= taken ? tgt : fall;
        if (upd_hit) begin
          btb_ctr_q[wr_idx] <= ctr_upd;
          if (taken) btb_target_q[wr_idx] <= tgt;
        end else if (taken) begin
          // Allocation biases branches to weakly-taken, jumps to strongly-taken.
          btb_valid_q[wr_idx]  <= 1'b1;
          btb_tag_q[wr_idx]    <= wr_tag;
          btb_target_q[wr_idx] <= tgt;
          btb_ctr_q[wr_idx]    <= is_br ? 2'b10 : 2'b11;
        end
      end else begin
        jb_valid_q       <= 1'b0;
        jb_out_q         <= '0;
        jb_taken_q       <= 1'b0;
        jb_mispredict_q  <= bus.ex_pred_taken;
        jb_redirect_pc_q <= fall;
      end
    end
  end

  assign bus.jb_valid       = jb_valid_q;
  assign bus.jb_out         = jb_out_q;
  assign bus.jb_taken       = jb_taken_q;
  assign bus.jb_mispredict  = jb_mispredict_q;
  assign bus.jb_redirect_pc = jb_redirect_pc_q;
endmodule

// File: tb/tb_jb_unit_btb.sv
// Bench for jb_unit_btb: directed scenarios plus randomized traffic checked against a
// PC-keyed behavioural model of the resolver and BTB.
module tb_jb_unit_btb;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 16;
  localparam logic [4:0] OpBr   = 5'b11000;
  localparam logic [4:0] OpJal  = 5'b11011;
  localparam logic [4:0] OpJalr = 5'b11001;
  localparam logic [4:0] OpAlu  = 5'b00100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  jb_unit_btb_if #(.XLEN(XLEN)) bus ();
  jb_unit_btb #(.XLEN(XLEN), .BTB_DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;

  // Model: each slot remembers the full PC that owns it.
  logic        m_valid [DEPTH];
  logic [31:0] m_pc    [DEPTH];
  logic [31:0] m_tgt   [DEPTH];
  int          m_ctr   [DEPTH];
  logic        e_valid, e_taken, e_mis;
  logic [31:0] e_out, e_redir;

  function automatic int slot_of(input logic [31:0] a);
    return int'(a / 4 % DEPTH);
  endfunction

  function automatic logic m_hit(input logic [31:0] a);
    int k;
    k = slot_of(a);
    return m_valid[k] && (m_pc[k][31:2] == a[31:2]);
  endfunction

  function automatic logic m_ptaken(input logic [31:0] a);
    return m_hit(a) && (m_ctr[slot_of(a)] >= 2);
  endfunction

  task automatic model_edge();
    logic [31:0] s;
    logic tk;
    int k;
    if (rst) begin
      e_valid = 0; e_out = 0; e_taken = 0; e_mis = 0; e_redir = 0;
      for (int i = 0; i < DEPTH; i++) begin
        m_valid[i] = 0; m_ctr[i] = 1; m_pc[i] = 0; m_tgt[i] = 0;
      end
    end else if (bus.stall) begin
    end else if (bus.flush || !bus.ex_valid) begin
      e_valid = 0; e_taken = 0; e_mis = 0;
    end else if (bus.opcode == OpBr || bus.opcode == OpJal || bus.opcode == OpJalr) begin
      s = bus.operand1 + bus.operand2;
      if (bus.opcode == OpJalr) s[0] = 1'b0;
      tk = (bus.opcode == OpBr) ? bus.br_cond : 1'b1;
      e_valid = 1; e_out = s; e_taken = tk;
      e_redir = tk ? s : bus.pc + 4;
      e_mis = (tk != bus.ex_pred_taken) || (tk && bus.ex_pred_taken && s != bus.ex_pred_target);
      k = slot_of(bus.pc);
      if (m_hit(bus.pc)) begin
        if (tk) begin
          if (m_ctr[k] < 3) m_ctr[k]++;
          m_tgt[k] = s;
        end else begin
          if (m_ctr[k] > 0) m_ctr[k]--;
        end
      end else if (tk) begin
        m_valid[k] = 1; m_pc[k] = bus.pc; m_tgt[k] = s;
        m_ctr[k] = (bus.opcode == OpBr) ? 2 : 3;
      end
    end else begin
      e_valid = 0; e_taken = 0; e_out = 0;
      e_mis = bus.ex_pred_taken; e_redir = bus.pc + 4;
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] op, input logic [31:0] p,
                       input logic [31:0] a, input logic [31:0] b, input logic bc,
                       input logic pt, input logic [31:0] ptg);
    bus.ex_valid = v; bus.opcode = op; bus.pc = p; bus.operand1 = a; bus.operand2 = b;
    bus.br_cond = bc; bus.ex_pred_taken = pt; bus.ex_pred_target = ptg;
    bus.stall = 0; bus.flush = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    drive(1, OpJal, 32'h40, 32'h40, 32'h10, 0, 0, 0);
    bus.if_pc = 32'h40;
    cycle();
    cycle();
    total++; if (bus.jb_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", bus.jb_valid); end
    total++; if (bus.jb_out !== 32'h0) begin bad++; $display("FAIL reset_out got=%h want=0", bus.jb_out); end
    total++; if (bus.jb_mispredict !== 1'b0 || bus.jb_taken !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b want=00", bus.jb_mispredict, bus.jb_taken); end
    total++; if (bus.jb_redirect_pc !== 32'h0) begin bad++; $display("FAIL reset_redir got=%h want=0", bus.jb_redirect_pc); end
    total++; if (bus.pred_hit !== 1'b0) begin bad++; $display("FAIL reset_hit got=%b want=0", bus.pred_hit); end
    rst = 0;
  endtask

  task automatic test_jalr();
    drive(1, OpJalr, 32'h1000, 32'h1003, 32'h4, 0, 1, 32'h1006);
    cycle();
    total++; if (bus.jb_valid !== 1'b1) begin bad++; $display("FAIL jalr_valid got=%b want=1", bus.jb_valid); end
    total++; if (bus.jb_out !== 32'h1006) begin bad++; $display("FAIL jalr_out got=%h want=1006", bus.jb_out); end
    total++; if (bus.jb_taken !== 1'b1) begin bad++; $display("FAIL jalr_taken got=%b want=1", bus.jb_taken); end
    total++; if (bus.jb_mispredict !== 1'b0) begin bad++; $display("FAIL jalr_mis got=%b want=0", bus.jb_mispredict); end
  endtask

  task automatic test_branch_not_taken();
    drive(1, OpBr, 32'h100, 32'h100, 32'h40, 0, 0, 0);
    cycle();
    total++; if (bus.jb_taken !== 1'b0) begin bad++; $display("FAIL bnt_taken got=%b want=0", bus.jb_taken); end
    total++; if (bus.jb_mispredict !== 1'b0) begin bad++; $display("FAIL bnt_mis got=%b want=0", bus.jb_mispredict); end
    total++; if (bus.jb_redirect_pc !== 32'h104) begin bad++; $display("FAIL bnt_redir got=%h want=104", bus.jb_redirect_pc); end
    bus.if_pc = 32'h100; #1;
    total++; if (bus.pred_hit !== 1'b0) begin bad++; $display("FAIL bnt_hit got=%b want=0", bus.pred_hit); end
  endtask

  task automatic test_counter();
    drive(1, OpBr, 32'h200, 32'h200, 32'h40, 1, 0, 0);
    cycle();
    total++; if (bus.jb_mispredict !== 1'b1) begin bad++; $display("FAIL ctr_alloc_mis got=%b want=1", bus.jb_mispredict); end
    bus.if_pc = 32'h200; #1;
    total++; if ({bus.pred_hit, bus.pred_taken} !== 2'b11) begin bad++; $display("FAIL ctr_alloc hit/taken got=%b%b want=11", bus.pred_hit, bus.pred_taken); end
    total++; if (bus.pred_target !== 32'h240) begin bad++; $display("FAIL ctr_alloc_tgt got=%h want=240", bus.pred_target); end
    for (int i = 0; i < 2; i++) begin
      drive(1, OpBr, 32'h200, 32'h200, 32'h40, 0, 1, 32'h240);
      cycle();
    end
    #1;
    total++; if ({bus.pred_hit, bus.pred_taken} !== 2'b10) begin bad++; $display("FAIL ctr_low hit/taken got=%b%b want=10", bus.pred_hit, bus.pred_taken); end
    for (int i = 0; i < 4; i++) begin
      drive(1, OpBr, 32'h200, 32'h200, 32'h40, 1, 1, 32'h240);
      cycle();
    end
    total++; if (bus.pred_taken !== 1'b1) begin bad++; $display("FAIL ctr_high taken got=%b want=1", bus.pred_taken); end
    // One not-taken from saturation (11 -> 10) must still predict taken.
    drive(1, OpBr, 32'h200, 32'h200, 32'h40, 0, 1, 32'h240);
    cycle();
    total++; if (bus.pred_taken !== 1'b1) begin bad++; $display("FAIL ctr_sat taken got=%b want=1", bus.pred_taken); end
    total++; if (bus.pred_taken !== m_ptaken(32'h200)) begin bad++; $display("FAIL ctr_model taken got=%b want=%b", bus.pred_taken, m_ptaken(32'h200)); end
  endtask

  task automatic test_alias();
    drive(1, OpJal, 32'h40, 32'h40, 32'h100, 0, 0, 0);
    cycle();
    drive(1, OpJal, 32'h80, 32'h80, 32'h20, 0, 0, 0);
    cycle();
    bus.if_pc = 32'h40; #1;
    total++; if (bus.pred_hit !== 1'b0) begin bad++; $display("FAIL alias_old_hit got=%b want=0", bus.pred_hit); end
    bus.if_pc = 32'h80; #1;
    total++; if (bus.pred_hit !== 1'b1 || bus.pred_target !== 32'hA0) begin bad++; $display("FAIL alias_new got=%b/%h want=1/a0", bus.pred_hit, bus.pred_target); end
  endtask

  task automatic test_mispredict();
    drive(1, OpAlu, 32'h500, 32'h0, 32'h0, 0, 1, 32'h300);
    cycle();
    total++; if (bus.jb_mispredict !== 1'b1) begin bad++; $display("FAIL nonjb_mis got=%b want=1", bus.jb_mispredict); end
    total++; if (bus.jb_redirect_pc !== 32'h504) begin bad++; $display("FAIL nonjb_redir got=%h want=504", bus.jb_redirect_pc); end
    total++; if (bus.jb_valid !== 1'b0 || bus.jb_out !== 32'h0) begin bad++; $display("FAIL nonjb_out got=%b/%h want=0/0", bus.jb_valid, bus.jb_out); end
    drive(1, OpJal, 32'h600, 32'h300, 32'h10, 0, 1, 32'h300);
    cycle();
    total++; if (bus.jb_mispredict !== 1'b1) begin bad++; $display("FAIL jal_tgt_mis got=%b want=1", bus.jb_mispredict); end
    total++; if (bus.jb_redirect_pc !== 32'h310) begin bad++; $display("FAIL jal_redir got=%h want=310", bus.jb_redirect_pc); end
    drive(1, OpJal, 32'h600, 32'h300, 32'h10, 0, 1, 32'h310);
    cycle();
    total++; if (bus.jb_mispredict !== 1'b0) begin bad++; $display("FAIL jal_ok_mis got=%b want=0", bus.jb_mispredict); end
  endtask

  task automatic test_control();
    drive(1, OpJal, 32'h700, 32'h20, 32'h20, 0, 0, 0);
    bus.stall = 1;
    cycle();
    total++; if (bus.jb_out !== 32'h310 || bus.jb_valid !== 1'b1) begin bad++; $display("FAIL stall_hold got=%b/%h want=1/310", bus.jb_valid, bus.jb_out); end
    bus.if_pc = 32'h700; #1;
    total++; if (bus.pred_hit !== 1'b0) begin bad++; $display("FAIL stall_btb got=%b want=0", bus.pred_hit); end
    drive(1, OpJal, 32'h704, 32'h900, 32'h0, 0, 0, 0);
    bus.flush = 1;
    cycle();
    total++; if (bus.jb_valid !== 1'b0 || bus.jb_taken !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b%b want=00", bus.jb_valid, bus.jb_taken); end
    total++; if (bus.jb_out !== 32'h310) begin bad++; $display("FAIL flush_hold got=%h want=310", bus.jb_out); end
    bus.if_pc = 32'h704; #1;
    total++; if (bus.pred_hit !== 1'b0) begin bad++; $display("FAIL flush_btb got=%b want=0", bus.pred_hit); end
    drive(1, OpJal, 32'h800, 32'hFFFFFFFC, 32'h8, 0, 0, 0);
    cycle();
    total++; if (bus.jb_out !== 32'h4) begin bad++; $display("FAIL wrap_out got=%h want=4", bus.jb_out); end
    rst = 1;
    drive(1, OpJal, 32'h900, 32'h10, 32'h10, 0, 1, 0);
    cycle();
    rst = 0;
    total++; if ({bus.jb_valid, bus.jb_taken, bus.jb_mispredict} !== 3'b000 || bus.jb_out !== 0 || bus.jb_redirect_pc !== 0) begin bad++; $display("FAIL midrst_out got=%b%b%b/%h/%h want=000/0/0", bus.jb_valid, bus.jb_taken, bus.jb_mispredict, bus.jb_out, bus.jb_redirect_pc); end
    foreach (m_pc[i]) begin
      bus.if_pc = 32'(i) << 2; #1;
      if (bus.pred_hit !== 1'b0) begin bad++; $display("FAIL midrst_hit idx=%0d got=1 want=0", i); end
    end
    total++;
    bus.if_pc = 32'h800; #1;
    total++; if (bus.pred_hit !== 1'b0) begin bad++; $display("FAIL midrst_800 got=%b want=0", bus.pred_hit); end
  endtask

  task automatic test_random();
    logic [31:0] p, q;
    logic [4:0] op;
    for (int n = 0; n < 400; n++) begin
      p = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 15) << 2);
      q = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 15) << 2);
      case ($urandom_range(0, 3))
        0: op = OpBr;
        1: op = OpJal;
        2: op = OpJalr;
        default: op = 5'($urandom);
      endcase
      drive($urandom_range(0, 7) != 0, op, p, $urandom, $urandom_range(0, 255),
            1'($urandom), 1'($urandom), $urandom);
      bus.stall = ($urandom_range(0, 9) == 0);
      bus.flush = ($urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 59) == 0);
      // Sometimes look up the PC being updated this cycle: lookup must see old contents.
      bus.if_pc = ($urandom_range(0, 1) == 0) ? p : q;
      #1;
      total++; if (bus.pred_hit !== m_hit(bus.if_pc) || bus.pred_taken !== m_ptaken(bus.if_pc)) begin bad++; $display("FAIL rnd_lookup n=%0d pc=%h got=%b%b want=%b%b", n, bus.if_pc, bus.pred_hit, bus.pred_taken, m_hit(bus.if_pc), m_ptaken(bus.if_pc)); end
      if (m_hit(bus.if_pc)) begin
        total++; if (bus.pred_target !== m_tgt[slot_of(bus.if_pc)]) begin bad++; $display("FAIL rnd_target n=%0d got=%h want=%h", n, bus.pred_target, m_tgt[slot_of(bus.if_pc)]); end
      end
      cycle();
      rst = 0;
      total++; if ({bus.jb_valid, bus.jb_taken, bus.jb_mispredict} !== {e_valid, e_taken, e_mis}) begin bad++; $display("FAIL rnd_flags n=%0d got=%b%b%b want=%b%b%b", n, bus.jb_valid, bus.jb_taken, bus.jb_mispredict, e_valid, e_taken, e_mis); end
      total++; if (bus.jb_out !== e_out || bus.jb_redirect_pc !== e_redir) begin bad++; $display("FAIL rnd_pcs n=%0d got=%h/%h want=%h/%h", n, bus.jb_out, bus.jb_redirect_pc, e_out, e_redir); end
    end
  endtask

  initial begin
    drive(0, OpAlu, 0, 0, 0, 0, 0, 0);
    bus.if_pc = 0;
    test_reset();
    test_jalr();
    test_branch_not_taken();
    test_counter();
    test_alias();
    test_mispredict();
    test_control();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
